// File: rtl/rv64g_pkg.sv
// Shared types for the rv64g front-end: prediction queue entries, BTB
// training payload and the update-channel state encoding.
package rv64g_pkg;

    localparam int XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
    } pred_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] curr_addr;
        logic [XLEN-1:0] next_addr;
        logic            is_jump;
    } btb_update_t;

    typedef enum logic {
        UPD_IDLE = 1'b0,
        UPD_PEND = 1'b1
    } upd_state_e;

endpackage

// File: rtl/tmd_pred_fifo.sv
// In-order queue of fetch predictions awaiting resolution.
// Flush wins over push and pop; the entry array itself is not reset.
module tmd_pred_fifo
    import rv64g_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  pred_entry_t i_data,
    input  logic        i_pop,
    input  logic        i_flush,
    output pred_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic        o_full,
    output logic        o_empty
);

    pred_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/tmd_branch_resolver.sv
// Execute-stage branch resolution: compares queued predictions with actual
// outcomes, flushes and redirects on mispredict, and trains the BTB.
module tmd_branch_resolver
    import rv64g_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            pred_valid_i,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic [XLEN-1:0] pred_next_pc_i,
    output logic            pred_ready_o,
    input  logic            res_valid_i,
    input  logic            res_is_jump_i,
    input  logic [XLEN-1:0] res_target_i,
    output logic            res_ready_o,
    output logic            upd_valid_o,
    output logic [XLEN-1:0] upd_curr_addr_o,
    output logic [XLEN-1:0] upd_next_addr_o,
    output logic            upd_is_jump_o,
    input  logic            upd_ready_i,
    output logic            pipeline_clear_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [CW-1:0]   inflight_o
);

    upd_state_e      r_state;
    upd_state_e      w_state_nxt;
    btb_update_t     r_upd;
    logic            r_clear;
    logic [XLEN-1:0] r_redirect;

    pred_entry_t     w_head;
    pred_entry_t     w_push_data;
    logic            w_full;
    logic            w_empty;
    logic [XLEN-1:0] w_actual;
    logic            w_mispred;
    logic            w_push;
    logic            w_res_fire;
    logic            w_mis_fire;

    // Gated by reset so fetch sees no room until reset is released.
    assign pred_ready_o = ~w_full & ~r_clear & ~arst_i;
    assign res_ready_o  = ~w_empty & (~upd_valid_o | upd_ready_i);

    assign w_push      = pred_valid_i & pred_ready_o;
    assign w_res_fire  = res_valid_i & res_ready_o;
    assign w_actual    = res_is_jump_i ? res_target_i : w_head.pc + XLEN'(4);
    assign w_mispred   = (w_actual != w_head.next_pc);
    assign w_mis_fire  = w_res_fire & w_mispred;
    assign w_push_data = '{pc: pred_pc_i, next_pc: pred_next_pc_i};

    tmd_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (arst_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_res_fire),
        .i_flush (w_mis_fire),
        .o_head  (w_head),
        .o_count (inflight_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_clear    <= 1'b0;
            r_redirect <= '0;
        end else begin
            r_clear    <= w_mis_fire;
            r_redirect <= w_mis_fire ? w_actual : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UPD_IDLE: if (w_mis_fire) w_state_nxt = UPD_PEND;
            UPD_PEND: if (upd_ready_i && !w_mis_fire) w_state_nxt = UPD_IDLE;
            default:  w_state_nxt = UPD_IDLE;
        endcase
    end

    // Payload only loads on an accepted mispredict, so it holds while stalled.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= UPD_IDLE;
            r_upd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mis_fire)
                r_upd <= '{curr_addr: w_head.pc, next_addr: w_actual, is_jump: res_is_jump_i};
        end
    end

    assign upd_valid_o      = (r_state == UPD_PEND);
    assign upd_curr_addr_o  = r_upd.curr_addr;
    assign upd_next_addr_o  = r_upd.next_addr;
    assign upd_is_jump_o    = r_upd.is_jump;
    assign pipeline_clear_o = r_clear;
    assign redirect_pc_o    = r_redirect;

endmodule

// File: tb/tb_tmd_branch_resolver.sv
// Directed bench for tmd_branch_resolver; inputs change and outputs are
// sampled on the falling clock edge.
module tb_tmd_branch_resolver;
    import rv64g_pkg::*;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic            pred_valid = 1'b0;
    logic [XLEN-1:0] pred_pc = '0;
    logic [XLEN-1:0] pred_next = '0;
    logic            pred_ready;
    logic            res_valid = 1'b0;
    logic            res_jump = 1'b0;
    logic [XLEN-1:0] res_tgt = '0;
    logic            res_ready;
    logic            upd_valid;
    logic [XLEN-1:0] upd_curr;
    logic [XLEN-1:0] upd_next;
    logic            upd_jump;
    logic            upd_ready = 1'b1;
    logic            clear;
    logic [XLEN-1:0] redirect;
    logic [3:0]      inflight;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmd_branch_resolver #(.DEPTH(8)) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .pred_valid_i     (pred_valid),
        .pred_pc_i        (pred_pc),
        .pred_next_pc_i   (pred_next),
        .pred_ready_o     (pred_ready),
        .res_valid_i      (res_valid),
        .res_is_jump_i    (res_jump),
        .res_target_i     (res_tgt),
        .res_ready_o      (res_ready),
        .upd_valid_o      (upd_valid),
        .upd_curr_addr_o  (upd_curr),
        .upd_next_addr_o  (upd_next),
        .upd_is_jump_o    (upd_jump),
        .upd_ready_i      (upd_ready),
        .pipeline_clear_o (clear),
        .redirect_pc_o    (redirect),
        .inflight_o       (inflight)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] nxt);
        pred_valid = 1'b1; pred_pc = pc; pred_next = nxt;
        @(negedge clk);
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic jmp, input logic [XLEN-1:0] tgt);
        res_valid = 1'b1; res_jump = jmp; res_tgt = tgt;
        @(negedge clk);
        res_valid = 1'b0; res_jump = 1'b0; res_tgt = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_upd_valid"}, XLEN'(upd_valid), '0);
        chk({tag, "_clear"},     XLEN'(clear), '0);
        chk({tag, "_redirect"},  redirect, '0);
        chk({tag, "_upd_curr"},  upd_curr, '0);
        chk({tag, "_upd_next"},  upd_next, '0);
        chk({tag, "_inflight"},  XLEN'(inflight), '0);
        chk({tag, "_res_ready"}, XLEN'(res_ready), '0);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_pred_ready", XLEN'(pred_ready), '0);
        chk_all_zero("rst");
        arst = 1'b0;
        #1;
        chk("rel_pred_ready", XLEN'(pred_ready), 64'd1);
        @(negedge clk);

        // Correct not-taken resolution
        push(64'h1000, 64'h1004);
        chk("t1_inflight1", XLEN'(inflight), 64'd1);
        chk("t1_res_ready", XLEN'(res_ready), 64'd1);
        resolve(1'b0, '0);
        chk("t1_inflight0", XLEN'(inflight), '0);
        chk("t1_clear", XLEN'(clear), '0);
        chk("t1_upd_valid", XLEN'(upd_valid), '0);

        // Taken mispredict flushes both entries
        push(64'h2000, 64'h2004);
        push(64'h2004, 64'h2008);
        chk("t2_inflight2", XLEN'(inflight), 64'd2);
        resolve(1'b1, 64'h3000);
        chk("t2_clear", XLEN'(clear), 64'd1);
        chk("t2_redirect", redirect, 64'h3000);
        chk("t2_upd_valid", XLEN'(upd_valid), 64'd1);
        chk("t2_upd_curr", upd_curr, 64'h2000);
        chk("t2_upd_next", upd_next, 64'h3000);
        chk("t2_upd_jump", XLEN'(upd_jump), 64'd1);
        chk("t2_inflight0", XLEN'(inflight), '0);
        chk("t2_pred_ready_clr", XLEN'(pred_ready), '0);
        @(negedge clk);
        chk("t2_clear_off", XLEN'(clear), '0);
        chk("t2_upd_idle", XLEN'(upd_valid), '0);

        // Fill to DEPTH
        for (int i = 0; i < 8; i++) push(64'h4000 + 64'(8 * i), 64'h4004 + 64'(8 * i));
        chk("t3_inflight8", XLEN'(inflight), 64'd8);
        chk("t3_pred_ready", XLEN'(pred_ready), '0);
        pred_valid = 1'b1; pred_pc = 64'h5000; pred_next = 64'h5004;
        @(negedge clk);
        chk("t3_ninth_held", XLEN'(inflight), 64'd8);
        // Pop at full: held push is still refused this cycle
        res_valid = 1'b1; res_jump = 1'b0;
        @(negedge clk);
        chk("t3_pop_at_full", XLEN'(inflight), 64'd7);
        chk("t3_ready_after", XLEN'(pred_ready), 64'd1);
        // Simultaneous push and correct pop
        @(negedge clk);
        pred_valid = 1'b0;
        chk("t3_push_pop", XLEN'(inflight), 64'd7);
        for (int i = 0; i < 7; i++) @(negedge clk);
        res_valid = 1'b0;
        chk("t3_drained", XLEN'(inflight), '0);
        chk("t3_no_clear", XLEN'(clear), '0);
        chk("t3_no_upd", XLEN'(upd_valid), '0);
        chk("t3_empty_ready", XLEN'(res_ready), '0);

        // Stalled BTB update
        upd_ready = 1'b0;
        push(64'h6000, 64'h6004);
        push(64'h6100, 64'h6104);
        resolve(1'b1, 64'h7000);
        chk("t4_upd_valid", XLEN'(upd_valid), 64'd1);
        @(negedge clk);
        push(64'h6200, 64'h6204);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_curr", upd_curr, 64'h6000);
            chk("t4_hold_next", upd_next, 64'h7000);
            chk("t4_hold_valid", XLEN'(upd_valid), 64'd1);
            chk("t4_res_stalled", XLEN'(res_ready), '0);
            @(negedge clk);
        end
        upd_ready = 1'b1;
        #1;
        chk("t4_res_unstall", XLEN'(res_ready), 64'd1);
        @(negedge clk);
        chk("t4_idle", XLEN'(upd_valid), '0);
        resolve(1'b0, '0);
        chk("t4_drained", XLEN'(inflight), '0);
        chk("t4_no_clear", XLEN'(clear), '0);

        // PC wrap at all-ones
        push(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        resolve(1'b0, '0);
        chk("t5_wrap_match", XLEN'(clear), '0);
        chk("t5_wrap_noupd", XLEN'(upd_valid), '0);
        push(64'hFFFF_FFFF_FFFF_FFFC, 64'h4);
        resolve(1'b0, '0);
        chk("t5_wrap_clear", XLEN'(clear), 64'd1);
        chk("t5_wrap_redirect", redirect, 64'h0);
        chk("t5_wrap_upd_curr", upd_curr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_wrap_upd_jump", XLEN'(upd_jump), '0);
        @(negedge clk);

        // Async reset during a pending update with 3 queued
        upd_ready = 1'b0;
        push(64'h8000, 64'h8004);
        resolve(1'b1, 64'h9000);
        chk("t6_clear", XLEN'(clear), 64'd1);
        @(negedge clk);
        push(64'hA000, 64'hA004);
        push(64'hA004, 64'hA008);
        push(64'hA008, 64'hA00C);
        chk("t6_inflight3", XLEN'(inflight), 64'd3);
        chk("t6_pend", XLEN'(upd_valid), 64'd1);
        #2 arst = 1'b1;
        #1;
        chk("t6_async_pred_ready", XLEN'(pred_ready), '0);
        chk_all_zero("t6_async");
        @(negedge clk);
        arst = 1'b0;
        upd_ready = 1'b1;
        #1;
        chk("t6_rel_pred_ready", XLEN'(pred_ready), 64'd1);
        @(negedge clk);
        chk_all_zero("t6_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
